frame_rate_meter: RTL and testbench
===================================

// Module: frame_rate_meter
// PURPOSE
//  Measures camera frame rate: counts frame-start edges of the camera FRAME_VALID
//  signal over a one-second window clocked by the 50 MHz system clock.
//  Result is published as packed BCD digits for the board's 7-segment decoders.
//  Generalises the fixed 4-digit FPS display: digit count, clock rate and
//  synchroniser depth are parameters; adds overflow/saturation and a result strobe.
// PARAMETERS
//  CLK_FREQ_HZ  50_000_000  clk cycles per measurement window (1 s); >= 2
//  N_DIGITS     4           BCD digits in result, 1..8
//  SYNC_STAGES  2           flops in frame_valid synchroniser, >= 2
// PORTS
//  clk          in   1            system clock
//  reset_n      in   1            async active-low reset
//  enable       in   1            1 = measure; 0 = hold window/counter at zero
//  frame_valid  in   1            camera FRAME_VALID, asynchronous to clk
//  bcd_out      out  4*N_DIGITS   last window's frame count, packed BCD, digit0 = [3:0]
//  rate_valid   out  1            1-cycle pulse when bcd_out updated
//  overflow     out  1            1 if last window saturated
//  window_cnt   out  16           number of completed windows, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (async assert, sync release): all flops 0; bcd_out=0, rate_valid=0,
//   overflow=0, window_cnt=0; synchroniser chain cleared to 0.
//  Synchroniser: frame_valid -> SYNC_STAGES flops -> fv_s; one extra flop fv_d.
//   frame_start = fv_s & ~fv_d (rising edge only; falling edge ignored).
//   Latency pin-to-frame_start: SYNC_STAGES+1 clk cycles.
//  Prescaler: presc counts 0..CLK_FREQ_HZ-1 while enable=1; tick=1 when
//   presc==CLK_FREQ_HZ-1 and enable=1; presc wraps to 0 on tick.
//  Accumulator: N_DIGITS-digit BCD counter acc; frame_start & enable -> +1 with
//   decimal carry (digit 9 -> 0, carry to next). At all-9s, further increments
//   leave acc at all-9s and set sat flag.
//  Window end (tick): registered update in next cycle:
//   bcd_out <= acc, overflow <= sat, rate_valid <= 1 (one cycle),
//   window_cnt <= window_cnt+1. Same cycle: acc <= 0, sat <= 0.
//  Simultaneous tick & frame_start: edge belongs to NEW window -> acc <= 1,
//   latched value excludes it.
//  enable=0: presc, acc, sat forced to 0 next cycle; bcd_out/overflow/window_cnt
//   hold; rate_valid=0. enable 0->1 starts a full fresh window (first tick after
//   CLK_FREQ_HZ cycles).
//  Reset mid-window: everything cleared, no rate_valid, partial count discarded.
//  States (implicit): IDLE (enable=0), COUNT (enable=1); no other FSM.
//  Throughput: one frame_start per 2 clk min (edge detector); faster toggling
//   is undercounted, not erroneous.
// TESTING (sim with CLK_FREQ_HZ=100, N_DIGITS=2, SYNC_STAGES=2)
//  Reset released, enable=1, 7 frame_valid pulses (5 clk hi/5 lo) in window ->
//   after 100 clks rate_valid pulses once, bcd_out=8'h07, overflow=0, window_cnt=1.
//  12 pulses in window -> bcd_out=8'h12 (BCD carry, not 8'h0C).
//  150 fast pulses (1 hi/1 lo) over 3 windows, 50/window at 2-clk spacing ->
//   >99 case: use CLK_FREQ_HZ=400 -> bcd_out=8'h99, overflow=1; next quiet window
//   -> bcd_out=8'h00, overflow=0.
//  frame_start forced on tick cycle -> that window's bcd_out excludes it, next
//   window's count includes it (+1).
//  enable dropped mid-window after 4 frames -> no rate_valid, bcd_out holds
//   previous value; re-enable, 3 frames -> bcd_out=8'h03 after 100 clks.
//  reset_n asserted mid-window asynchronously (off clock edge) -> all outputs 0
//   immediately; no rate_valid until a full window after release.

Source files
------------

// File: rtl/frame_rate_meter.sv
// frame_rate_meter: counts FRAME_VALID rising edges per CLK_FREQ_HZ-cycle window and publishes them as packed BCD
//   clk, reset_n (async active-low), enable (0 holds window/count at zero), frame_valid (async camera input)
//   bcd_out (last window count, digit0 = [3:0]), rate_valid (1-cycle update strobe),
//   overflow (last window saturated), window_cnt (completed windows, wraps)
module frame_rate_meter #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int N_DIGITS    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  frame_valid,
  output logic [4*N_DIGITS-1:0] bcd_out,
  output logic                  rate_valid,
  output logic                  overflow,
  output logic [15:0]           window_cnt
);
  localparam int PW = $clog2(CLK_FREQ_HZ);
  localparam int BW = 4 * N_DIGITS;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   fv_d_q;
  logic [PW-1:0]          presc_q, presc_d;
  logic [BW-1:0]          acc_q, acc_d, acc_inc, bcd_q;
  logic                   sat_q, sat_d, rv_q, ov_q, carry, frame_start, tick;
  logic [15:0]            wcnt_q;
  assign frame_start = sync_q[SYNC_STAGES-1] & ~fv_d_q;
  assign tick        = enable && presc_q == PW'(CLK_FREQ_HZ - 1);
  assign bcd_out     = bcd_q;
  assign rate_valid  = rv_q;
  assign overflow    = ov_q;
  assign window_cnt  = wcnt_q;
  // Decimal ripple increment; carry out of the top digit means acc is all nines.
  always_comb begin
    acc_inc = acc_q;
    carry   = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (carry) begin
        if (acc_q[4*i+:4] == 4'd9) acc_inc[4*i+:4] = 4'd0;
        else begin
          acc_inc[4*i+:4] = acc_q[4*i+:4] + 4'd1;
          carry           = 1'b0;
        end
      end
    end
  end
  // An edge landing on the tick cycle opens the new window with a count of one.
  always_comb begin
    presc_d = '0;
    acc_d   = '0;
    sat_d   = 1'b0;
    if (enable) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      acc_d   = tick ? BW'(frame_start) : (frame_start && !carry) ? acc_inc : acc_q;
      sat_d   = !tick && (sat_q || (frame_start && carry));
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      fv_d_q  <= 1'b0;
      presc_q <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      rv_q    <= 1'b0;
      ov_q    <= 1'b0;
      bcd_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], frame_valid};
      fv_d_q  <= sync_q[SYNC_STAGES-1];
      presc_q <= presc_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      rv_q    <= tick;
      if (tick) begin
        bcd_q  <= acc_q;
        ov_q   <= sat_q;
        wcnt_q <= wcnt_q + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_frame_rate_meter.sv
// tb_frame_rate_meter: scoreboard bench with an integer-count window model for frame_rate_meter
module tb_frame_rate_meter;
  localparam int CLK = 300;
  localparam int ND  = 2;
  localparam int S   = 2;
  typedef struct {
    logic [7:0]  bcd;
    logic        ov;
    logic [15:0] wc;
    int          due;
  } exp_t;
  logic        clk, reset_n, enable, frame_valid;
  logic [7:0]  bcd_out;
  logic        rate_valid, overflow;
  logic [15:0] window_cnt;
  int          checks, failures, ncyc, wcyc, cnt, w;
  logic [15:0] wc;
  logic [24:0] last;
  bit   [S:0]  h;
  bit          saw_sat;
  exp_t        q[$];
  frame_rate_meter #(.CLK_FREQ_HZ(CLK), .N_DIGITS(ND), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .frame_valid(frame_valid),
    .bcd_out(bcd_out), .rate_valid(rate_valid), .overflow(overflow), .window_cnt(window_cnt)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] to_bcd(input int c);
    int v;
    v = c > 99 ? 99 : c;
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction
  // Reference: frame_valid as seen at each clock; its rising edges are credited S+1 clocks later,
  // windows are CLK consecutive enabled clocks, and a result is due the clock after a window closes.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h    = '0;
      cnt  = 0;
      wcyc = 0;
      wc   = '0;
      q.delete();
    end else begin
      bit fs;
      ncyc++;
      fs = h[S-1] && !h[S];
      if (enable) begin
        wcyc++;
        if (wcyc == CLK) begin
          q.push_back('{to_bcd(cnt), cnt > 99, wc + 16'd1, ncyc});
          wc++;
          cnt  = int'(fs);
          wcyc = 0;
        end else cnt += int'(fs);
      end else begin
        cnt  = 0;
        wcyc = 0;
      end
      h = {h[S-1:0], frame_valid};
    end
  end
  always @(negedge clk) begin
    if (!reset_n) last = '0;
    if (rate_valid) begin
      if (q.size() == 0) chk("spurious_rate_valid", 32'(rate_valid), 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("rv_cycle", 32'(ncyc), 32'(e.due));
        chk("bcd_out", 32'(bcd_out), 32'(e.bcd));
        chk("overflow", 32'(overflow), 32'(e.ov));
        chk("window_cnt", 32'(window_cnt), 32'(e.wc));
        last = {e.bcd, e.ov, e.wc};
        if (bcd_out == 8'h99 && overflow) saw_sat = 1'b1;
      end
    end else begin
      if (q.size() != 0 && q[0].due <= ncyc) begin
        chk("missed_rate_valid", 32'(rate_valid), 32'd1);
        void'(q.pop_front());
      end
      chk("hold", 32'({bcd_out, overflow, window_cnt}), 32'(last));
    end
  end
  task automatic pulses(input int n, input int hi, input int lo);
    repeat (n) begin
      frame_valid = 1'b1;
      repeat (hi) @(negedge clk);
      frame_valid = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask
  task automatic wait_rv(input int budget, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!rate_valid && waited < budget);
    if (!rate_valid) chk("rv_timeout", 32'd0, 32'd1);
  endtask
  initial begin
    checks = 0; failures = 0; ncyc = 0; saw_sat = 1'b0; last = '0;
    reset_n = 1'b1; enable = 1'b0; frame_valid = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_bcd", 32'(bcd_out), 32'd0);
    chk("reset_wc", 32'(window_cnt), 32'd0);
    chk("reset_rv_ov", 32'({rate_valid, overflow}), 32'd0);
    #3 reset_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    pulses(7, 5, 5);
    wait_rv(2 * CLK, w);
    chk("seven_bcd", 32'(bcd_out), 32'h07);
    chk("seven_ov", 32'(overflow), 32'd0);
    chk("seven_wc", 32'(window_cnt), 32'd1);
    pulses(12, 5, 5);
    wait_rv(2 * CLK, w);
    chk("twelve_bcd", 32'(bcd_out), 32'h12);
    pulses(200, 1, 1);
    wait_rv(2 * CLK, w);
    wait_rv(2 * CLK, w);
    chk("saturated_window_seen", 32'(saw_sat), 32'd1);
    chk("quiet_bcd", 32'(bcd_out), 32'h00);
    chk("quiet_ov", 32'(overflow), 32'd0);
    w = 0;
    while (wcyc != CLK - 1 - S && w < 2 * CLK) begin
      @(negedge clk);
      w++;
    end
    frame_valid = 1'b1;
    wait_rv(CLK, w);
    chk("tick_edge_excluded", 32'(bcd_out), 32'h00);
    frame_valid = 1'b0;
    wait_rv(2 * CLK, w);
    chk("tick_edge_next_window", 32'(bcd_out), 32'h01);
    pulses(4, 5, 5);
    enable = 1'b0;
    repeat (20) @(negedge clk);
    chk("disabled_hold_bcd", 32'(bcd_out), 32'h01);
    enable = 1'b1;
    pulses(3, 5, 5);
    wait_rv(CLK + 10, w);
    chk("reenable_bcd", 32'(bcd_out), 32'h03);
    pulses(5, 5, 5);
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async_reset_bcd", 32'(bcd_out), 32'd0);
    chk("async_reset_wc", 32'(window_cnt), 32'd0);
    chk("async_reset_rv_ov", 32'({rate_valid, overflow}), 32'd0);
    repeat (2) @(negedge clk);
    #3 reset_n = 1'b1;
    wait_rv(CLK + 20, w);
    chk("post_reset_window_len", 32'(w), 32'(CLK));
    chk("post_reset_wc", 32'(window_cnt), 32'd1);
    repeat (1500) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) frame_valid = ~frame_valid;
      if ($urandom_range(0, 249) == 0) enable = ~enable;
    end
    enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
